axi4_mem_responder: RTL and testbench
=====================================

# axi4_mem_responder

Synthesizable AXI4 memory responder (slave) that terminates the full-width memory master port of the accelerator wrapper with an on-chip word-addressed RAM. It lets wrapper-level designs and benches run real AXI4 read and write bursts without an external memory controller. Independent read and write state machines serve one burst each at a time, with byte-strobed writes and a registered read path.

## Interface
- ADDR_W, 64, address width of AW/AR
- DATA_W, 512, data width; bytes per beat BPB = DATA_W/8
- ID_W, 6, transaction ID width
- DEPTH_LOG2, 10, RAM holds 2^DEPTH_LOG2 words of DATA_W bits

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all FSMs and outputs, not RAM contents
- mem_AWVALID/AWREADY  in/out  1  write address handshake
- mem_AWADDR  in  ADDR_W  burst start byte address
- mem_AWLEN  in  8  beats minus one
- mem_AWID  in  ID_W  write ID
- mem_AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS  in  3/2/1/4/3/4  accepted and ignored
- mem_WVALID/WREADY  in/out  1  write data handshake
- mem_WDATA  in  DATA_W; mem_WSTRB  in  BPB; mem_WLAST  in  1
- mem_BVALID  out  1; mem_BREADY  in  1; mem_BID  out  ID_W; mem_BRESP  out  2
- mem_ARVALID/ARREADY  in/out  1; mem_ARADDR  in  ADDR_W; mem_ARLEN  in  8; mem_ARID  in  ID_W
- mem_ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS  in  ignored
- mem_RVALID  out  1; mem_RREADY  in  1; mem_RDATA  out  DATA_W; mem_RID  out  ID_W; mem_RLAST  out  1; mem_RRESP  out  2

## Operation
- Word index = ADDR[log2(BPB)+DEPTH_LOG2-1 : log2(BPB)]; low bits ignored; all bursts treated as INCR; index wraps modulo 2^DEPTH_LOG2.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1; on handshake latch index, AWLEN, AWID, clear beat counter and error flag.
  - W_DATA: WREADY=1; each handshake writes bytes where WSTRB=1, index+1, beat+1; after beat AWLEN → W_RESP.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=OKAY(0) or SLVERR(2); held stable until BREADY, then W_IDLE.
- Read FSM R_IDLE -> R_FETCH -> R_DATA.
  - R_IDLE: ARREADY=1; on handshake latch index, ARLEN, ARID.
  - R_FETCH: register RAM[index] into RDATA; → R_DATA.
  - R_DATA: RVALID=1, RID=latched, RRESP=0, RLAST=(beat==ARLEN); outputs stable until RREADY; on handshake last → R_IDLE, else index+1, beat+1 → R_FETCH.
- Simultaneous write and read fetch to same index: read returns old data.
- Reset mid-burst: both FSMs to IDLE immediately; partial write beats remain in RAM; no B/R response issued.

## Timing
- Reset values: AWREADY=ARREADY=0 while reset high, 1 from first cycle after release; WREADY, BVALID, RVALID, RLAST=0; BID, BRESP, RID, RRESP, RDATA=0.
- AW accepted cycle t: WREADY from t+1; one beat per cycle max.
- Last W handshake cycle t: BVALID at t+1; AWREADY again the cycle after B handshake.
- AR accepted cycle t: RVALID at t+2; with RREADY held high, one beat every 2 cycles; ARREADY again cycle after last R handshake.
- Read and write paths fully independent; no cross-channel ordering.

## Configuration
- AXI4_MEM_RESP_WLAST_CHECK_EN defined: WLAST on beat other than AWLEN, or missing on beat AWLEN, sets error flag → BRESP=SLVERR; early WLAST ends the burst at that beat.
- Undefined: WLAST ignored; burst length from AWLEN only; BRESP always OKAY.

## Test plan
- Write AWADDR=0x40, AWLEN=3, WSTRB all-ones, data 1..4; read back ARADDR=0x40, ARLEN=3 -> RDATA 1,2,3,4, RLAST only on beat 3, RID=ARID, BRESP=0.
- Partial strobe: write word 5 with 0xAA.., then WSTRB=0x1 data 0x55 -> read returns 0xAA..AA55.
- RREADY low 5 cycles mid-burst -> RVALID, RDATA, RLAST held stable; no beat lost or duplicated.
- With AXI4_MEM_RESP_WLAST_CHECK_EN, AWLEN=3 and WLAST on beat 1 -> BRESP=2, words 2-3 unchanged; without it -> BRESP=0, all 4 beats written.
- Index wrap: DEPTH_LOG2=4, AWADDR at word 15, AWLEN=1 -> second beat lands in word 0.
- Assert reset during beat 2 of an 8-beat read -> RVALID=0 immediately, ARREADY=1 after release, new AR served normally.

Source files
------------

// File: rtl/axi4_mem_responder_if.sv
// AXI4 memory-port bundle between an accelerator master and axi4_mem_responder.
// The master modport drives requests; the slave modport drives the ready/response side.
interface axi4_mem_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 6
);
  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_W-1:0]     AWADDR;
  logic [7:0]            AWLEN;
  logic [ID_W-1:0]       AWID;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWLOCK;
  logic [3:0]            AWCACHE;
  logic [2:0]            AWPROT;
  logic [3:0]            AWQOS;

  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  WLAST;

  logic                  BVALID;
  logic                  BREADY;
  logic [ID_W-1:0]       BID;
  logic [1:0]            BRESP;

  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_W-1:0]     ARADDR;
  logic [7:0]            ARLEN;
  logic [ID_W-1:0]       ARID;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARLOCK;
  logic [3:0]            ARCACHE;
  logic [2:0]            ARPROT;
  logic [3:0]            ARQOS;

  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_W-1:0]     RDATA;
  logic [ID_W-1:0]       RID;
  logic                  RLAST;
  logic [1:0]            RRESP;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWID, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS,
    input  AWREADY,
    output WVALID, WDATA, WSTRB, WLAST,
    input  WREADY,
    input  BVALID, BID, BRESP,
    output BREADY,
    output ARVALID, ARADDR, ARLEN, ARID, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS,
    input  ARREADY,
    input  RVALID, RDATA, RID, RLAST, RRESP,
    output RREADY
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWID, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS,
    output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST,
    output WREADY,
    output BVALID, BID, BRESP,
    input  BREADY,
    input  ARVALID, ARADDR, ARLEN, ARID, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS,
    output ARREADY,
    output RVALID, RDATA, RID, RLAST, RRESP,
    input  RREADY
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by an on-chip word RAM; independent one-burst-at-a-time read and write FSMs.
// Define AXI4_MEM_RESP_WLAST_CHECK_EN to have WLAST checked against AWLEN (SLVERR on mismatch).
module axi4_mem_responder #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int ID_W       = 6,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  axi4_mem_responder_if.slave  mem
);
  localparam int BPB = DATA_W / 8;
  localparam int LSB = $clog2(BPB);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  logic [DATA_W-1:0]     r_ram [2**DEPTH_LOG2];

  wstate_t               r_wstate, w_wnext;
  logic [DEPTH_LOG2-1:0] r_widx;
  logic [7:0]            r_wlen, r_wbeat;
  logic [ID_W-1:0]       r_wid;
  logic                  w_awready, w_wready, w_bvalid, w_wfire, w_werrset;
  logic                  r_werr;

  rstate_t               r_rstate, w_rnext;
  logic [DEPTH_LOG2-1:0] r_ridx;
  logic [7:0]            r_rlen, r_rbeat;
  logic [ID_W-1:0]       r_rid;
  logic [DATA_W-1:0]     r_rdata;
  logic                  w_arready, w_rvalid, w_rlastbeat;

  logic [ADDR_W-1:0]     w_awaddr, w_araddr;
  logic                  w_unused;

  assign w_awaddr = mem.AWADDR;
  assign w_araddr = mem.ARADDR;
  assign w_unused = ^{w_awaddr, w_araddr, mem.WLAST,
                      mem.AWSIZE, mem.AWBURST, mem.AWLOCK, mem.AWCACHE, mem.AWPROT, mem.AWQOS,
                      mem.ARSIZE, mem.ARBURST, mem.ARLOCK, mem.ARCACHE, mem.ARPROT, mem.ARQOS};

  always_comb begin
    w_wnext   = r_wstate;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    w_werrset = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = 1'b1;
        if (mem.AWVALID) w_wnext = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (mem.WVALID) begin
`ifdef AXI4_MEM_RESP_WLAST_CHECK_EN
          // Early WLAST terminates the burst; either mismatch direction is flagged.
          w_werrset = (mem.WLAST != (r_wbeat == r_wlen));
          if (mem.WLAST || (r_wbeat == r_wlen)) w_wnext = W_RESP;
`else
          if (r_wbeat == r_wlen) w_wnext = W_RESP;
`endif
        end
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (mem.BREADY) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  assign w_wfire = w_wready & mem.WVALID;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wbeat  <= '0;
      r_wid    <= '0;
      r_werr   <= 1'b0;
    end else begin
      r_wstate <= w_wnext;
      if (w_awready && mem.AWVALID) begin
        r_widx  <= w_awaddr[LSB +: DEPTH_LOG2];
        r_wlen  <= mem.AWLEN;
        r_wid   <= mem.AWID;
        r_wbeat <= '0;
        r_werr  <= 1'b0;
      end else if (w_wfire) begin
        r_widx  <= r_widx + 1'b1;
        r_wbeat <= r_wbeat + 8'd1;
        r_werr  <= r_werr | w_werrset;
      end
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wfire) begin
      for (int b = 0; b < BPB; b++) begin
        if (mem.WSTRB[b]) r_ram[r_widx][b*8 +: 8] <= mem.WDATA[b*8 +: 8];
      end
    end
  end

  assign mem.AWREADY = w_awready & ~reset;
  assign mem.WREADY  = w_wready;
  assign mem.BVALID  = w_bvalid;
  assign mem.BID     = r_wid;
  assign mem.BRESP   = r_werr ? 2'b10 : 2'b00;

  assign w_rlastbeat = (r_rbeat == r_rlen);

  always_comb begin
    w_rnext   = r_rstate;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = 1'b1;
        if (mem.ARVALID) w_rnext = R_FETCH;
      end
      R_FETCH: w_rnext = R_DATA;
      R_DATA: begin
        w_rvalid = 1'b1;
        if (mem.RREADY) w_rnext = w_rlastbeat ? R_IDLE : R_FETCH;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  // A fetch colliding with a same-cycle write to that word sees the pre-write contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rbeat  <= '0;
      r_rid    <= '0;
      r_rdata  <= '0;
    end else begin
      r_rstate <= w_rnext;
      if (w_arready && mem.ARVALID) begin
        r_ridx  <= w_araddr[LSB +: DEPTH_LOG2];
        r_rlen  <= mem.ARLEN;
        r_rid   <= mem.ARID;
        r_rbeat <= '0;
      end
      if (r_rstate == R_FETCH) r_rdata <= r_ram[r_ridx];
      if (w_rvalid && mem.RREADY && !w_rlastbeat) begin
        r_ridx  <= r_ridx + 1'b1;
        r_rbeat <= r_rbeat + 8'd1;
      end
    end
  end

  assign mem.ARREADY = w_arready & ~reset;
  assign mem.RVALID  = w_rvalid;
  assign mem.RDATA   = r_rdata;
  assign mem.RID     = r_rid;
  assign mem.RLAST   = w_rvalid & w_rlastbeat;
  assign mem.RRESP   = 2'b00;
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder with a 16-word RAM so index wrap is reachable.
// Expectations follow AXI4_MEM_RESP_WLAST_CHECK_EN when the bench is built with it.
module tb_axi4_mem_responder;
  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 512;
  localparam int ID_W       = 6;
  localparam int DEPTH_LOG2 = 4;
  localparam int BPB        = DATA_W / 8;
  localparam int TIMEOUT    = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nPass = 0;

  logic [DATA_W-1:0] wData [8];
  logic [BPB-1:0]    wStrb [8];
  logic [DATA_W-1:0] rExp  [8];

  always #5 clk = ~clk;

  axi4_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) memIf ();

  axi4_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem(memIf)
  );

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyWriteStimulus(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                    input logic [ID_W-1:0] id, input int lastBeat,
                                    input logic [1:0] expResp);
    int n, waitCnt;
    logic rdy;
    memIf.AWVALID = 1'b1;
    memIf.AWADDR  = addr;
    memIf.AWLEN   = len;
    memIf.AWID    = id;
    waitCnt = 0;
    do begin
      rdy = memIf.AWREADY;
      tick();
      waitCnt++;
    end while (!rdy && waitCnt < TIMEOUT);
    memIf.AWVALID = 1'b0;
    checkOutput("aw_handshake", rdy, 1);
    if (!rdy) return;
    checkOutput("wready_after_aw", memIf.WREADY, 1);
    n = int'(len) + 1;
`ifdef AXI4_MEM_RESP_WLAST_CHECK_EN
    if (lastBeat < n - 1) n = lastBeat + 1;
`endif
    for (int i = 0; i < n; i++) begin
      memIf.WVALID = 1'b1;
      memIf.WDATA  = wData[i];
      memIf.WSTRB  = wStrb[i];
      memIf.WLAST  = (i == lastBeat);
      waitCnt = 0;
      do begin
        rdy = memIf.WREADY;
        tick();
        waitCnt++;
      end while (!rdy && waitCnt < TIMEOUT);
      if (!rdy) begin
        checkOutput("w_handshake_timeout", 0, 1);
        break;
      end
    end
    memIf.WVALID = 1'b0;
    memIf.WLAST  = 1'b0;
    checkOutput("bvalid_after_last_w", memIf.BVALID, 1);
    checkOutput("bresp", memIf.BRESP, expResp);
    checkOutput("bid", memIf.BID, id);
    memIf.BREADY = 1'b1;
    tick();
    memIf.BREADY = 1'b0;
    checkOutput("bvalid_clear", memIf.BVALID, 0);
    checkOutput("awready_after_b", memIf.AWREADY, 1);
  endtask

  task automatic applyReadStimulus(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                   input logic [ID_W-1:0] id, input int stallBeat,
                                   input int abortBeat);
    int waitCnt;
    logic rdy;
    memIf.ARVALID = 1'b1;
    memIf.ARADDR  = addr;
    memIf.ARLEN   = len;
    memIf.ARID    = id;
    waitCnt = 0;
    do begin
      rdy = memIf.ARREADY;
      tick();
      waitCnt++;
    end while (!rdy && waitCnt < TIMEOUT);
    memIf.ARVALID = 1'b0;
    checkOutput("ar_handshake", rdy, 1);
    if (!rdy) return;
    checkOutput("rvalid_not_early", memIf.RVALID, 0);
    memIf.RREADY = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stallBeat) memIf.RREADY = 1'b0;
      waitCnt = 0;
      while (!memIf.RVALID && waitCnt < TIMEOUT) begin
        tick();
        waitCnt++;
      end
      checkOutput($sformatf("r_latency_beat%0d", i), waitCnt, 1);
      if (!memIf.RVALID) break;
      if (i == abortBeat) begin
        reset = 1'b1;
        #1;
        checkOutput("rvalid_in_reset", memIf.RVALID, 0);
        checkOutput("arready_in_reset", memIf.ARREADY, 0);
        memIf.RREADY = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("arready_after_reset", memIf.ARREADY, 1);
        checkOutput("rvalid_after_reset", memIf.RVALID, 0);
        return;
      end
      checkOutput($sformatf("rdata_beat%0d", i), memIf.RDATA, rExp[i]);
      checkOutput($sformatf("rlast_beat%0d", i), memIf.RLAST, (i == int'(len)));
      checkOutput("rid", memIf.RID, id);
      checkOutput("rresp", memIf.RRESP, 0);
      if (i == stallBeat) begin
        for (int k = 0; k < 5; k++) begin
          tick();
          checkOutput("stall_rvalid", memIf.RVALID, 1);
          checkOutput("stall_rdata", memIf.RDATA, rExp[i]);
          checkOutput("stall_rlast", memIf.RLAST, (i == int'(len)));
        end
        memIf.RREADY = 1'b1;
      end
      tick();
    end
    memIf.RREADY = 1'b0;
    checkOutput("rvalid_clear", memIf.RVALID, 0);
    checkOutput("arready_after_r", memIf.ARREADY, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    memIf.AWVALID = 1'b0; memIf.AWADDR = '0; memIf.AWLEN = '0; memIf.AWID = '0;
    memIf.AWSIZE = 3'd6; memIf.AWBURST = 2'd1; memIf.AWLOCK = 1'b0; memIf.AWCACHE = '0;
    memIf.AWPROT = '0; memIf.AWQOS = '0;
    memIf.WVALID = 1'b0; memIf.WDATA = '0; memIf.WSTRB = '0; memIf.WLAST = 1'b0;
    memIf.BREADY = 1'b0;
    memIf.ARVALID = 1'b0; memIf.ARADDR = '0; memIf.ARLEN = '0; memIf.ARID = '0;
    memIf.ARSIZE = 3'd6; memIf.ARBURST = 2'd1; memIf.ARLOCK = 1'b0; memIf.ARCACHE = '0;
    memIf.ARPROT = '0; memIf.ARQOS = '0;
    memIf.RREADY = 1'b0;

    repeat (3) tick();
    checkOutput("reset_awready", memIf.AWREADY, 0);
    checkOutput("reset_arready", memIf.ARREADY, 0);
    checkOutput("reset_wready", memIf.WREADY, 0);
    checkOutput("reset_bvalid", memIf.BVALID, 0);
    checkOutput("reset_rvalid", memIf.RVALID, 0);
    checkOutput("reset_rlast", memIf.RLAST, 0);
    checkOutput("reset_rdata", memIf.RDATA, 0);
    checkOutput("reset_bresp", memIf.BRESP, 0);
    checkOutput("reset_bid", memIf.BID, 0);
    checkOutput("reset_rid", memIf.RID, 0);
    reset = 1'b0;
    tick();
    checkOutput("awready_after_release", memIf.AWREADY, 1);
    checkOutput("arready_after_release", memIf.ARREADY, 1);

    // Four-beat write at word 1, read back with a 5-cycle stall on beat 1.
    for (int i = 0; i < 4; i++) begin
      wData[i] = DATA_W'(i + 1);
      wStrb[i] = '1;
      rExp[i]  = DATA_W'(i + 1);
    end
    applyWriteStimulus(64'h40, 8'd3, 6'd5, 3, 2'b00);
    applyReadStimulus(64'h40, 8'd3, 6'd9, 1, -1);

    // Byte-strobed overwrite of word 5.
    wData[0] = {BPB{8'hAA}};
    wStrb[0] = '1;
    applyWriteStimulus(64'h140, 8'd0, 6'd1, 0, 2'b00);
    wData[0] = DATA_W'(8'h55);
    wStrb[0] = BPB'(1);
    applyWriteStimulus(64'h140, 8'd0, 6'd2, 0, 2'b00);
    rExp[0] = {{(BPB-1){8'hAA}}, 8'h55};
    applyReadStimulus(64'h140, 8'd0, 6'd3, -1, -1);

    // WLAST asserted early on beat 1 of a four-beat burst over words 8..11.
    for (int i = 0; i < 4; i++) begin
      wData[i] = DATA_W'(8'h10 + i);
      wStrb[i] = '1;
    end
    applyWriteStimulus(64'h200, 8'd3, 6'd4, 3, 2'b00);
    for (int i = 0; i < 4; i++) wData[i] = DATA_W'(8'h20 + i);
`ifdef AXI4_MEM_RESP_WLAST_CHECK_EN
    applyWriteStimulus(64'h200, 8'd3, 6'd6, 1, 2'b10);
    rExp[0] = DATA_W'(8'h20); rExp[1] = DATA_W'(8'h21);
    rExp[2] = DATA_W'(8'h12); rExp[3] = DATA_W'(8'h13);
`else
    applyWriteStimulus(64'h200, 8'd3, 6'd6, 1, 2'b00);
    rExp[0] = DATA_W'(8'h20); rExp[1] = DATA_W'(8'h21);
    rExp[2] = DATA_W'(8'h22); rExp[3] = DATA_W'(8'h23);
`endif
    applyReadStimulus(64'h200, 8'd3, 6'd7, -1, -1);

    // Two-beat write starting at word 15 wraps its second beat into word 0.
    wData[0] = DATA_W'(8'h77); wStrb[0] = '1;
    wData[1] = DATA_W'(8'h78); wStrb[1] = '1;
    applyWriteStimulus(64'h3C0, 8'd1, 6'd10, 1, 2'b00);
    rExp[0] = DATA_W'(8'h78);
    applyReadStimulus(64'h0, 8'd0, 6'd11, -1, -1);
    rExp[0] = DATA_W'(8'h77); rExp[1] = DATA_W'(8'h78);
    applyReadStimulus(64'h3C0, 8'd1, 6'd12, -1, -1);

    // Reset on beat 2 of an eight-beat read, then a fresh read of word 5.
    rExp[0] = DATA_W'(1); rExp[1] = DATA_W'(2);
    applyReadStimulus(64'h40, 8'd7, 6'd13, -1, 2);
    rExp[0] = {{(BPB-1){8'hAA}}, 8'h55};
    applyReadStimulus(64'h140, 8'd0, 6'd14, -1, -1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
